pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline.
//  - Drives write-enable and flush strobes for the PC and the IF/ID, ID/EX and EX/MEM registers.
//  - Resolves load-use hazards, taken branches, jumps and data-memory wait states.
//  - Drains and halts the pipe on request, and keeps saturating stall/flush counters.
// PARAMETERS
//  CNT_W     16  width of stall_cnt / flush_cnt
//  MAX_WAIT  64  consecutive mem_busy cycles before mem_timeout is set (>=2)
//  DRAIN_CYC 4   NOP-injection cycles before halted asserts (>=1)
// PORTS
//  sysclk          in  1      clock, rising edge
//  reset           in  1      asynchronous, active-high
//  id_rs           in  5      rs field of instruction in ID
//  id_rt           in  5      rt field of instruction in ID
//  id_uses_rt      in  1      ID instruction reads rt
//  ex_mem_read     in  1      instruction in EX is a load
//  ex_rt           in  5      destination (rt) of load in EX
//  id_jump         in  1      jump decoded in ID
//  ex_branch_taken in  1      branch in EX resolved taken
//  mem_busy        in  1      data memory not ready this cycle
//  halt_req        in  1      level request to drain and halt
//  clr_cnt         in  1      synchronous clear of both counters and mem_timeout
//  pc_write        out 1      PC load enable
//  if_id_write     out 1      IF/ID load enable
//  if_id_flush     out 1      IF/ID loads NOP
//  id_ex_write     out 1      ID/EX load enable
//  id_ex_flush     out 1      ID/EX loads zero control (bubble)
//  ex_mem_write    out 1      EX/MEM and MEM/WB load enable
//  halted          out 1      pipe drained and stopped
//  mem_timeout     out 1      sticky memory-wait timeout flag
//  stall_cnt       out CNT_W  cycles with pc_write=0 (saturating)
//  flush_cnt       out CNT_W  cycles with if_id_flush=1 (saturating)
// BEHAVIOUR
//  Strobes are combinational from state and inputs; counters and flags are registered.
//  While reset=1:
//   - state=RUN; wait_cnt=0; drain_cnt=0; counters=0; mem_timeout=0; halted=0.
//   - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0; if_id_flush=1, id_ex_flush=1.
//  Hazard terms:
//   - lu = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  Default (all enables=1, flushes=0). Priority within RUN, highest first:
//   1 mem_busy: all enables=0, no flush; next state MEM_WAIT.
//   2 ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1.
//   3 lu: pc_write=0, if_id_write=0, id_ex_flush=1 (one bubble; no extra state).
//   4 id_jump: if_id_flush=1.
//   5 halt_req: next state DRAIN, drain_cnt=0.
//  MEM_WAIT:
//   - Strobes as case 1 while mem_busy=1; wait_cnt increments, saturating at MAX_WAIT.
//   - wait_cnt reaching MAX_WAIT sets mem_timeout (sticky until clr_cnt or reset); state stays MEM_WAIT.
//   - mem_busy=0: wait_cnt<=0, return to RUN, and RUN priorities 2-5 apply in that same cycle.
//  DRAIN:
//   - pc_write=0, if_id_flush=1; other stages advance; drain_cnt increments.
//   - mem_busy=1: full hold, drain_cnt frozen, wait_cnt counts as in MEM_WAIT.
//   - drain_cnt==DRAIN_CYC-1 (and mem_busy=0) -> HALTED.
//   - halt_req dropping mid-drain -> RUN next cycle.
//   - Branch/lu/jump are ignored: no new fetches enter during DRAIN.
//  HALTED:
//   - halted=1; all enables=0, no flushes.
//   - halt_req=0 -> RUN next cycle; halted=0 in RUN.
//  Counters:
//   - stall_cnt +1 each non-reset cycle with pc_write=0, including DRAIN/HALTED.
//   - flush_cnt +1 each cycle with if_id_flush=1.
//   - Both saturate at 2^CNT_W-1; clr_cnt has priority over increment.
//  Reset mid-operation: async return to RUN; all pending waits and drains are discarded.
// TESTING
//  - Load in EX with ex_rt=5, id_rs=5 -> 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1, then normal.
//  - Load-use with ex_rt=0, or id_rt match with id_uses_rt=0 -> no stall.
//  - ex_branch_taken=1 with lu=1 in the same cycle -> pc_write=1, both flushes=1; stall_cnt unchanged, flush_cnt +1.
//  - mem_busy for 3 cycles -> all enables 0 for 3 cycles, RUN on 4th; mem_busy for 64 cycles -> mem_timeout=1 stays set until clr_cnt.
//  - halt_req=1 held, DRAIN_CYC=4 -> 4 flush cycles, then halted=1; halt_req=0 -> halted=0 next cycle; mem_busy mid-drain extends drain by the busy cycles.
//  - Reset pulse during MEM_WAIT -> immediate reset outputs; after release RUN, wait_cnt=0, counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Brief    : Hazard-controller bundle: pipeline status in, stage strobes out.
//  Revision : 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             id_jump;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             halt_req;
  logic             clr_cnt;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, id_jump,
           ex_branch_taken, mem_busy, halt_req, clr_cnt,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, halted, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, id_jump,
           ex_branch_taken, mem_busy, halt_req, clr_cnt,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, halted, mem_timeout, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Stall/flush sequencer for a 5-stage pipe with drain/halt support.
//  Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_WAIT  = 64,
  parameter int DRAIN_CYC = 4
) (
  input  logic                   sysclk_i,
  input  logic                   reset_i,
  pipeline_hazard_ctrl_if.slave  hz_if
);
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(MAX_WAIT);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               timeout_q, timeout_d;
  logic               halted_q;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic lu;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w;

  assign lu = hz_if.ex_mem_read && (hz_if.ex_rt != 5'd0) &&
              ((hz_if.ex_rt == hz_if.id_rs) ||
               (hz_if.id_uses_rt && (hz_if.ex_rt == hz_if.id_rt)));

  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_f  = 1'b0;
    exmem_w = 1'b1;
    if (reset_i) begin
      {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
      ifid_f = 1'b1;
      idex_f = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN, S_MEM_WAIT: begin
          // A cycle leaving MEM_WAIT behaves exactly like RUN
          if (hz_if.mem_busy) begin
            {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          end else if (hz_if.ex_branch_taken) begin
            ifid_f = 1'b1;
            idex_f = 1'b1;
          end else if (lu) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_f = 1'b1;
          end else if (hz_if.id_jump) begin
            ifid_f = 1'b1;
          end
        end
        S_DRAIN: begin
          if (hz_if.mem_busy) begin
            {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          end else begin
            pc_w   = 1'b0;
            ifid_f = 1'b1;
          end
        end
        default: begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    wait_d  = '0;
    if (hz_if.mem_busy && (state_q != S_HALTED)) begin
      wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 1'b1;
    end
    unique case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (hz_if.mem_busy) begin
          state_d = S_MEM_WAIT;
        end else if (hz_if.halt_req && !hz_if.ex_branch_taken && !lu && !hz_if.id_jump) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!hz_if.halt_req) begin
          state_d = S_RUN;
          drain_d = '0;
        end else if (!hz_if.mem_busy) begin
          if (drain_q == DRAIN_END) begin
            state_d = S_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      default: begin
        if (!hz_if.halt_req) begin
          state_d = S_RUN;
        end
      end
    endcase

    timeout_d = hz_if.clr_cnt ? 1'b0 : (timeout_q || (wait_d == WAIT_LIM));

    stall_d = stall_q;
    flush_d = flush_q;
    if (hz_if.clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_w && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
      if (ifid_f && (flush_q != CNT_MAX)) flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
      halted_q  <= (state_d == S_HALTED);
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign hz_if.pc_write     = pc_w;
  assign hz_if.if_id_write  = ifid_w;
  assign hz_if.if_id_flush  = ifid_f;
  assign hz_if.id_ex_write  = idex_w;
  assign hz_if.id_ex_flush  = idex_f;
  assign hz_if.ex_mem_write = exmem_w;
  assign hz_if.halted       = halted_q;
  assign hz_if.mem_timeout  = timeout_q;
  assign hz_if.stall_cnt    = stall_q;
  assign hz_if.flush_cnt    = flush_q;
endmodule
`default_nettype wire
